// File: rtl/dm_store_buffer.sv
// Store FIFO between EX/MEM and data memory with youngest-match load forwarding.
// Enqueue-to-DM latency 1 cycle; ST_READY drops when full (STALL holds pipeline), DM_EN gates drain.
module dm_store_buffer #(
   parameter int DEPTH  = 4,
   parameter int PTR_W  = 2,
   parameter int IDX_HI = 11
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             ST_VALID,
   input  logic [31:0]      ST_ADDR,
   input  logic [31:0]      ST_DATA,
   input  logic [31:0]      ST_PC,
   output logic             ST_READY,
   output logic             STALL,
   input  logic [31:0]      LD_ADDR,
   output logic             LD_HIT,
   output logic [31:0]      LD_DATA,
   input  logic             DM_EN,
   output logic             DM_WE,
   output logic [31:0]      DM_ADDR,
   output logic [31:0]      DM_WDATA,
   output logic [31:0]      DM_PC,
   output logic [PTR_W:0]   COUNT,
   output logic             EMPTY,
   output logic             FULL
);

   localparam int IDX_W = IDX_HI - 1;
   localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic [31:0]      data;
      logic [31:0]      pc;
   } entry_t;

   entry_t             mem [DEPTH];
   logic [PTR_W-1:0]   head;
   logic [PTR_W-1:0]   tail;
   logic [PTR_W:0]     count;
   logic [PTR_W-1:0]   slot;
   logic               enq;
   logic               deq;
   logic [IDX_W-1:0]   ld_idx;
   logic               unused_addr_bits;

   // Upper address bits alias onto the 1024-word DM; byte offset is ignored.
   assign unused_addr_bits = ^{ST_ADDR[31:IDX_HI+1], ST_ADDR[1:0],
                               LD_ADDR[31:IDX_HI+1], LD_ADDR[1:0]};

   assign ld_idx   = LD_ADDR[IDX_HI:2];
   assign COUNT    = count;
   assign EMPTY    = (count == '0);
   assign FULL     = (count == DEPTH_CNT);
   assign ST_READY = !FULL;
   assign STALL    = ST_VALID & FULL;
   assign enq      = ST_VALID & ST_READY;
   assign DM_WE    = !EMPTY & DM_EN & !Reset;
   assign deq      = DM_WE;

   assign DM_ADDR  = {{(30-IDX_W){1'b0}}, mem[head].idx, 2'b00};
   assign DM_WDATA = mem[head].data;
   assign DM_PC    = mem[head].pc;

   always_ff @(posedge CLK) begin
      if (Reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq) tail <= tail + 1'b1;
         if (deq) head <= head + 1'b1;
         case ({enq, deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Contents need no reset: COUNT masks stale entries.
   always_ff @(posedge CLK) begin
      if (enq) begin
         mem[tail].idx  <= ST_ADDR[IDX_HI:2];
         mem[tail].data <= ST_DATA;
         mem[tail].pc   <= ST_PC;
      end
   end

   // Walk oldest to youngest so the last match wins.
   always_comb begin
      LD_HIT  = 1'b0;
      LD_DATA = '0;
      slot    = '0;
      for (int k = 0; k < DEPTH; k++) begin
         slot = head + k[PTR_W-1:0];
         if ((k[PTR_W:0] < count) && (mem[slot].idx == ld_idx)) begin
            LD_HIT  = 1'b1;
            LD_DATA = mem[slot].data;
         end
      end
   end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed bench for dm_store_buffer: drain timing, full/stall, forwarding, wrap, reset, aliasing.
module tb_dm_store_buffer;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        ST_VALID;
   logic [31:0] ST_ADDR, ST_DATA, ST_PC;
   logic        ST_READY, STALL;
   logic [31:0] LD_ADDR;
   logic        LD_HIT;
   logic [31:0] LD_DATA;
   logic        DM_EN;
   logic        DM_WE;
   logic [31:0] DM_ADDR, DM_WDATA, DM_PC;
   logic [2:0]  COUNT;
   logic        EMPTY, FULL;

   int vec = 0;
   int err = 0;
   logic [63:0] wr_q [$];

   dm_store_buffer #(.DEPTH(4), .PTR_W(2), .IDX_HI(11)) dut (
      .CLK(CLK), .Reset(Reset),
      .ST_VALID(ST_VALID), .ST_ADDR(ST_ADDR), .ST_DATA(ST_DATA), .ST_PC(ST_PC),
      .ST_READY(ST_READY), .STALL(STALL),
      .LD_ADDR(LD_ADDR), .LD_HIT(LD_HIT), .LD_DATA(LD_DATA),
      .DM_EN(DM_EN), .DM_WE(DM_WE), .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA), .DM_PC(DM_PC),
      .COUNT(COUNT), .EMPTY(EMPTY), .FULL(FULL)
   );

   always #5 CLK = ~CLK;

   // Inputs settle by posedge+1, so the negedge value is what the next edge commits.
   always @(negedge CLK) if (DM_WE === 1'b1) wr_q.push_back({DM_ADDR, DM_WDATA});

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1; ST_VALID = 1'b0; DM_EN = 1'b0;
      tick();
      Reset = 1'b0;
      #1;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d);
      ST_VALID = 1'b1; ST_ADDR = a; ST_DATA = d; ST_PC = d + 32'h400;
      tick();
      ST_VALID = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      DM_EN = 1'b1; #1;
      vec++; if (EMPTY !== 1'b1 || FULL !== 1'b0 || ST_READY !== 1'b1) begin
         err++; $display("FAIL reset_flags EMPTY/FULL/RDY=%b%b%b required 101", EMPTY, FULL, ST_READY); end
      vec++; if (COUNT !== 3'd0) begin err++; $display("FAIL reset_count got %0d required 0", COUNT); end
      vec++; if (DM_WE !== 1'b0 || LD_HIT !== 1'b0) begin
         err++; $display("FAIL reset_we_hit WE=%b HIT=%b required 0 0", DM_WE, LD_HIT); end
      DM_EN = 1'b0;
   endtask

   task automatic test_basic();
      do_reset();
      DM_EN = 1'b1; ST_VALID = 1'b1; ST_ADDR = 32'h10; ST_DATA = 32'hAAAA_0001; ST_PC = 32'h0000_0040;
      #1;
      vec++; if (DM_WE !== 1'b0) begin err++; $display("FAIL basic_nobypass DM_WE=%b required 0", DM_WE); end
      tick();
      ST_VALID = 1'b0; #1;
      vec++; if (DM_WE !== 1'b1 || DM_ADDR !== 32'h10 || DM_WDATA !== 32'hAAAA_0001) begin
         err++; $display("FAIL basic_drain WE=%b ADDR=%h DATA=%h required 1 00000010 aaaa0001", DM_WE, DM_ADDR, DM_WDATA); end
      vec++; if (DM_PC !== 32'h40) begin err++; $display("FAIL basic_pc got %h required 00000040", DM_PC); end
      tick();
      vec++; if (EMPTY !== 1'b1 || DM_WE !== 1'b0) begin
         err++; $display("FAIL basic_empty EMPTY=%b WE=%b required 1 0", EMPTY, DM_WE); end
      DM_EN = 1'b0;
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < 4; i++) push(32'h40 + 32'(i*4), 32'h100 + 32'(i));
      ST_VALID = 1'b1; ST_ADDR = 32'h50; ST_DATA = 32'h104; #1;
      vec++; if (COUNT !== 3'd4 || FULL !== 1'b1) begin
         err++; $display("FAIL full_count COUNT=%0d FULL=%b required 4 1", COUNT, FULL); end
      vec++; if (STALL !== 1'b1 || ST_READY !== 1'b0) begin
         err++; $display("FAIL full_stall STALL=%b RDY=%b required 1 0", STALL, ST_READY); end
      wr_q.delete();
      DM_EN = 1'b1; #1;
      vec++; if (ST_READY !== 1'b0 || STALL !== 1'b1) begin
         err++; $display("FAIL full_nopass RDY=%b STALL=%b required 0 1", ST_READY, STALL); end
      ST_VALID = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      vec++; if (wr_q.size() !== 4) begin err++; $display("FAIL full_drain_n got %0d required 4", wr_q.size()); end
      for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
         vec++; if (wr_q[i] !== {32'h40 + 32'(i*4), 32'h100 + 32'(i)}) begin
            err++; $display("FAIL full_order[%0d] got %h required %h", i, wr_q[i], {32'h40 + 32'(i*4), 32'h100 + 32'(i)}); end
      end
      vec++; if (EMPTY !== 1'b1) begin err++; $display("FAIL full_empty got %b required 1", EMPTY); end
      DM_EN = 1'b0;
   endtask

   task automatic test_forward();
      do_reset();
      push(32'h20, 32'd1);
      push(32'h20, 32'd2);
      LD_ADDR = 32'h23; #1;
      vec++; if (LD_HIT !== 1'b1 || LD_DATA !== 32'd2) begin
         err++; $display("FAIL fwd_youngest HIT=%b DATA=%h required 1 00000002", LD_HIT, LD_DATA); end
      LD_ADDR = 32'h24; #1;
      vec++; if (LD_HIT !== 1'b0 || LD_DATA !== 32'd0) begin
         err++; $display("FAIL fwd_miss HIT=%b DATA=%h required 0 00000000", LD_HIT, LD_DATA); end
      ST_VALID = 1'b1; ST_ADDR = 32'h24; ST_DATA = 32'd9; #1;
      vec++; if (LD_HIT !== 1'b0) begin err++; $display("FAIL fwd_same_cycle_enq HIT=%b required 0", LD_HIT); end
      ST_VALID = 1'b0;
      LD_ADDR = 32'h20; DM_EN = 1'b1;
      tick();
      vec++; if (LD_HIT !== 1'b1 || LD_DATA !== 32'd2 || DM_WE !== 1'b1) begin
         err++; $display("FAIL fwd_draining HIT=%b DATA=%h WE=%b required 1 00000002 1", LD_HIT, LD_DATA, DM_WE); end
      tick();
      vec++; if (LD_HIT !== 1'b0) begin err++; $display("FAIL fwd_after_drain HIT=%b required 0", LD_HIT); end
      DM_EN = 1'b0; LD_ADDR = 32'hFFC;
   endtask

   task automatic test_back_to_back();
      do_reset();
      push(32'h80, 32'h200);
      push(32'h84, 32'h201);
      wr_q.delete();
      DM_EN = 1'b1;
      for (int i = 0; i < 6; i++) begin
         ST_VALID = 1'b1; ST_ADDR = 32'h88 + 32'(i*4); ST_DATA = 32'h202 + 32'(i);
         tick();
         vec++; if (COUNT !== 3'd2) begin err++; $display("FAIL b2b_count[%0d] got %0d required 2", i, COUNT); end
      end
      ST_VALID = 1'b0;
      tick(); tick();
      vec++; if (wr_q.size() !== 8 || COUNT !== 3'd0) begin
         err++; $display("FAIL b2b_total writes=%0d COUNT=%0d required 8 0", wr_q.size(), COUNT); end
      for (int i = 0; i < 8 && i < wr_q.size(); i++) begin
         vec++; if (wr_q[i] !== {32'h80 + 32'(i*4), 32'h200 + 32'(i)}) begin
            err++; $display("FAIL b2b_order[%0d] got %h required %h", i, wr_q[i], {32'h80 + 32'(i*4), 32'h200 + 32'(i)}); end
      end
      DM_EN = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 3; i++) push(32'h300 + 32'(i*4), 32'h55 + 32'(i));
      vec++; if (COUNT !== 3'd3) begin err++; $display("FAIL rst_pre_count got %0d required 3", COUNT); end
      wr_q.delete();
      DM_EN = 1'b1; Reset = 1'b1; #1;
      vec++; if (DM_WE !== 1'b0) begin err++; $display("FAIL rst_we_gated got %b required 0", DM_WE); end
      tick();
      Reset = 1'b0; #1;
      vec++; if (COUNT !== 3'd0 || EMPTY !== 1'b1) begin
         err++; $display("FAIL rst_count COUNT=%0d EMPTY=%b required 0 1", COUNT, EMPTY); end
      for (int i = 0; i < 3; i++) tick();
      vec++; if (wr_q.size() !== 0) begin err++; $display("FAIL rst_no_writes got %0d required 0", wr_q.size()); end
      DM_EN = 1'b0;
   endtask

   task automatic test_alias();
      do_reset();
      push(32'h1000_0010, 32'd7);
      DM_EN = 1'b1; LD_ADDR = 32'h10; #1;
      vec++; if (DM_ADDR !== 32'h10 || DM_WDATA !== 32'd7 || DM_WE !== 1'b1) begin
         err++; $display("FAIL alias_dm ADDR=%h DATA=%h WE=%b required 00000010 00000007 1", DM_ADDR, DM_WDATA, DM_WE); end
      vec++; if (LD_HIT !== 1'b1 || LD_DATA !== 32'd7) begin
         err++; $display("FAIL alias_fwd HIT=%b DATA=%h required 1 00000007", LD_HIT, LD_DATA); end
      tick();
      DM_EN = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; ST_VALID = 1'b0; ST_ADDR = '0; ST_DATA = '0; ST_PC = '0;
      LD_ADDR = 32'hFFC; DM_EN = 1'b0;
      test_reset();
      test_basic();
      test_full();
      test_forward();
      test_back_to_back();
      test_reset_mid();
      test_alias();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
